hier_func_prod_accum: RTL and testbench
=======================================

# hier_func_prod_accum

Frame accumulator that sits directly downstream of the 15×6 unsigned pipelined multiplier in `hier_func`. It consumes the multiplier's 21-bit products under a valid/ready handshake and sums one frame of products. It then emits a rounded, right-shifted and saturated result per frame. Its `in_ready` drives the multiplier's clock enable, so backpressure freezes the whole upstream pipeline.

## Interface
- `DIN_WIDTH`, 21: product width, the multiplier's dout.
- `FRAME_LEN`, 64: products per frame, at least 2.
- `ACC_WIDTH`, 28: accumulator width, at least DIN_WIDTH + clog2(FRAME_LEN) + 1.
- `SHIFT`, 6: right shift applied to the frame sum, at least 1.
- `DOUT_WIDTH`, 16: result width.
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: `in_data` is valid. It is aligned with the multiplier output by the caller's valid delay line.
- `in_data`, in, DIN_WIDTH: unsigned product.
- `in_last`, in, 1: ends the frame early when it arrives with a sample.
- `in_ready`, out, 1: accept; the caller wires it to the multiplier `ce` and to the valid delay line.
- `out_valid`, out, 1: result register holds a frame result.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, DOUT_WIDTH: rounded, shifted, saturated frame sum.
- `out_sat`, out, 1: saturation occurred for this result.
- `out_short`, out, 1: frame was closed by `in_last` before FRAME_LEN samples.

## Operation
- **Accept.** A sample is accepted when `in_valid && in_ready`. Nothing changes on cycles without an accept.
- **Accumulate.** On accept, `acc <= (cnt==0 ? 0 : acc) + in_data` and `cnt` increments.
- **Frame close.** A frame closes on the accept where `cnt==FRAME_LEN-1` or `in_last==1`.
  - On close, the result register loads `r = (acc_next + 2^(SHIFT-1)) >> SHIFT`.
  - `out_data = (r > 2^DOUT_WIDTH-1) ? 2^DOUT_WIDTH-1 : r`.
  - `out_sat = (r > 2^DOUT_WIDTH-1)`.
  - `out_short = (cnt != FRAME_LEN-1)`.
  - `out_valid` is set and `cnt` returns to 0.
  - `in_last` on the FRAME_LEN-th sample is a normal close with `out_short=0`.
- **Output handshake.** The result transfers when `out_valid && out_ready`. `out_valid` then clears unless a new close happens in the same cycle, in which case the new result loads and `out_valid` stays 1.
- **Overlap.** The next frame keeps accumulating while a result is pending; only the closing sample waits.
- **Backpressure.** `in_ready = !(out_valid && !out_ready && closing_candidate)`, where `closing_candidate = (cnt==FRAME_LEN-1) || (in_valid && in_last)`.
  - This is combinational from `out_ready` and `in_last`; the path is documented and accepted.
- **State machine.** Two states, encoded by `out_valid`:
  - EMPTY → FULL on close.
  - FULL → EMPTY on output transfer with no close in the same cycle.
  - FULL → FULL on transfer plus close.
- **Arithmetic.** All arithmetic is unsigned. The rounding add is done at ACC_WIDTH+1 bits so it never wraps.

## Timing
- **Reset values.** `reset=1` at an edge forces `acc=0`, `cnt=0`, `out_valid=0`, `out_data=0`, `out_sat=0`, `out_short=0`.
  - `in_ready` is 1 from the first cycle after reset.
  - A partial frame or a pending result at reset is discarded.
- **Latency.** 1 cycle from the closing accept to `out_valid=1` with the result on the outputs.
- **Throughput.** 1 sample per cycle. A result held with `out_ready=0` stalls input only at a frame boundary.
- **Stability.** `out_data`, `out_sat` and `out_short` are stable while `out_valid && !out_ready`.
- **Gaps.** `in_valid` gaps of any length leave `acc` and `cnt` unchanged.

## Structure
- **Shared package `hier_func_pkg`:**
  - width constants DIN_WIDTH=21, ACC_WIDTH, DOUT_WIDTH.
  - `clog2` function for sizing `cnt`.
  - `round_shift_sat` function.
- **Sub-module `hier_func_round_sat`:** combinational round, shift and saturate. It has ports `acc`, `res`, `sat` and is reused by later scaling stages.
- **Top level:** accumulator, counter, result register and ready logic.

## Test plan
- **Full frame.** 64 samples of 100 back-to-back, `out_ready=1` → one cycle after the 64th accept: `out_valid=1`, `out_data=100` (6432>>6), `out_sat=0`, `out_short=0`.
- **Saturation.** 64 samples of 2097151 → `out_data=65535`, `out_sat=1`.
- **Rounding and short frame.** A single sample 32 with `in_last=1` → `out_data=1`, `out_short=1`. A single sample 31 with `in_last=1` → `out_data=0`.
- **Backpressure.** `out_ready=0` across two full frames of value 64 → first result `out_data=64` held stable. `in_ready=0` while the 64th sample of frame 2 is presented. Raising `out_ready` transfers result 1 and accepts the sample in the same cycle. Result 2 `out_data=64` follows one cycle later; no sample is lost or duplicated.
- **Reset mid-operation.** Assert `reset` after 30 samples → all outputs 0. The next 64 samples of 1 give `out_data=1` (96>>6), with no residue from the aborted frame.
- **Random gaps.** Random `in_valid` gaps and random `out_ready` over 1000 frames → results match a reference model; `acc` is unchanged on idle cycles.

Source files
------------

// File: rtl/hier_func_pkg.sv
// Shared constants, types and helpers for the hier_func datapath stages
// downstream of the 15x6 product multiplier.
package hier_func_pkg;

   localparam int DIN_WIDTH  = 21;
   localparam int FRAME_LEN  = 64;
   localparam int ACC_WIDTH  = 28;
   localparam int SHIFT      = 6;
   localparam int DOUT_WIDTH = 16;
   localparam int ACC_RWIDTH = ACC_WIDTH + 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } res_state_e;

   typedef struct packed {
      logic [DOUT_WIDTH-1:0] data;
      logic                  sat;
   } rs_result_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Scalar form of the round/shift/saturate stage at the package widths.
   function automatic rs_result_t round_shift_sat(input logic [ACC_WIDTH-1:0] acc);
      logic [ACC_RWIDTH-1:0] sum;
      logic [ACC_RWIDTH-1:0] r;
      rs_result_t            o;
      sum    = {1'b0, acc} + (ACC_RWIDTH'(1) << (SHIFT - 1));
      r      = sum >> SHIFT;
      o.sat  = (r > ACC_RWIDTH'((1 << DOUT_WIDTH) - 1));
      o.data = o.sat ? '1 : r[DOUT_WIDTH-1:0];
      return o;
   endfunction

endpackage

// File: rtl/hier_func_prod_accum_if.sv
// Product-in / frame-result-out handshake bundle of the frame accumulator.
interface hier_func_prod_accum_if #(
   parameter int DIN_W  = 21,
   parameter int DOUT_W = 16
);
   logic              in_valid;
   logic [DIN_W-1:0]  in_data;
   logic              in_last;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DOUT_W-1:0] out_data;
   logic              out_sat;
   logic              out_short;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_short
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_short
   );
endinterface

// File: rtl/hier_func_round_sat.sv
// Combinational round-half-up, right shift and unsigned saturation; shared
// by the accumulator and later scaling stages.
module hier_func_round_sat #(
   parameter int ACC_W  = 28,
   parameter int SHIFT  = 6,
   parameter int DOUT_W = 16
) (
   input  logic [ACC_W-1:0]  acc,
   output logic [DOUT_W-1:0] res,
   output logic              sat
);
   // One extra bit keeps the rounding add from wrapping at full scale.
   localparam int              RW      = ACC_W + 1;
   localparam logic [RW-1:0]   RES_MAX = {{(RW-DOUT_W){1'b0}}, {DOUT_W{1'b1}}};
   localparam logic [RW-1:0]   HALF    = RW'(1) << (SHIFT - 1);

   logic [RW-1:0] w_sum;
   logic [RW-1:0] w_shifted;

   assign w_sum     = {1'b0, acc} + HALF;
   assign w_shifted = w_sum >> SHIFT;
   assign sat       = (w_shifted > RES_MAX);
   assign res       = sat ? {DOUT_W{1'b1}} : w_shifted[DOUT_W-1:0];

endmodule

// File: rtl/hier_func_prod_accum.sv
// Frame accumulator: sums one frame of multiplier products and emits a
// rounded, shifted, saturated result; in_ready doubles as the multiplier ce.
module hier_func_prod_accum
   import hier_func_pkg::*;
#(
   parameter int DIN_WIDTH  = hier_func_pkg::DIN_WIDTH,
   parameter int FRAME_LEN  = hier_func_pkg::FRAME_LEN,
   parameter int ACC_WIDTH  = hier_func_pkg::ACC_WIDTH,
   parameter int SHIFT      = hier_func_pkg::SHIFT,
   parameter int DOUT_WIDTH = hier_func_pkg::DOUT_WIDTH
) (
   input logic                   clk,
   input logic                   reset,
   hier_func_prod_accum_if.slave bus
);
   localparam int               CNT_W    = clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   logic [ACC_WIDTH-1:0]  r_acc;
   logic [CNT_W-1:0]      r_cnt;
   res_state_e            r_state;
   logic [DOUT_WIDTH-1:0] r_out_data;
   logic                  r_out_sat;
   logic                  r_out_short;

   logic                  w_at_last;
   logic                  w_candidate;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_close;
   logic [ACC_WIDTH-1:0]  w_acc_base;
   logic [ACC_WIDTH-1:0]  w_acc_next;
   logic [DOUT_WIDTH-1:0] w_res;
   logic                  w_sat;

   // Only a sample that would close a frame waits on a pending result, so
   // the next frame keeps filling while downstream is stalled.
   assign w_at_last   = (r_cnt == LAST_IDX);
   assign w_candidate = w_at_last || (bus.in_valid && bus.in_last);
   assign w_in_ready  = !((r_state == ST_FULL) && !bus.out_ready && w_candidate);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_close     = w_accept && (w_at_last || bus.in_last);

   assign w_acc_base  = (r_cnt == '0) ? '0 : r_acc;
   assign w_acc_next  = w_acc_base + ACC_WIDTH'(bus.in_data);

   hier_func_round_sat #(
      .ACC_W  (ACC_WIDTH),
      .SHIFT  (SHIFT),
      .DOUT_W (DOUT_WIDTH)
   ) u_round_sat (
      .acc (w_acc_next),
      .res (w_res),
      .sat (w_sat)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_state     <= ST_EMPTY;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_short <= 1'b0;
      end else begin
         if (w_accept) begin
            r_acc <= w_acc_next;
            r_cnt <= w_close ? '0 : r_cnt + 1'b1;
         end

         case (r_state)
            ST_EMPTY: if (w_close) r_state <= ST_FULL;
            ST_FULL:  if (bus.out_ready && !w_close) r_state <= ST_EMPTY;
            default:  r_state <= ST_EMPTY;
         endcase

         if (w_close) begin
            r_out_data  <= w_res;
            r_out_sat   <= w_sat;
            r_out_short <= !w_at_last;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == ST_FULL);
   assign bus.out_data  = r_out_data;
   assign bus.out_sat   = r_out_sat;
   assign bus.out_short = r_out_short;

endmodule

// File: tb/tb_hier_func_prod_accum.sv
// Directed and random checks of the frame accumulator against a frame-level
// queue model of accepted samples and pending results.
module tb_hier_func_prod_accum;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hier_func_prod_accum_if #(.DIN_W(21), .DOUT_W(16)) bus ();

   hier_func_prod_accum dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int unsigned data;
      bit          sat;
      bit          short_f;
   } res_t;

   res_t    exp_q[$];
   longint  m_sum;
   int      m_cnt;
   int      n_checks = 0;
   int      n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic res_t frame_result(input longint sum, input int n);
      res_t   r;
      longint q;
      q         = (sum + 32) / 64;
      r.sat     = (q > 65535);
      r.data    = r.sat ? 65535 : int'(q);
      r.short_f = (n != 64);
      return r;
   endfunction

   // One cycle: drive at the falling edge, check settled outputs, update model.
   task automatic step(input bit v, input int unsigned d, input bit l, input bit ordy);
      bit          exp_rdy;
      bit          pending;
      int unsigned dd;
      dd            = d & 32'h1F_FFFF;
      bus.in_valid  = v;
      bus.in_data   = dd[20:0];
      bus.in_last   = l;
      bus.out_ready = ordy;
      #1;
      pending = (exp_q.size() != 0);
      exp_rdy = !(pending && !ordy && (m_cnt == 63 || (v && l)));
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("out_valid", bus.out_valid, pending);
      if (pending) begin
         chk("out_data", bus.out_data, exp_q[0].data);
         chk("out_sat", bus.out_sat, exp_q[0].sat);
         chk("out_short", bus.out_short, exp_q[0].short_f);
         if (ordy) void'(exp_q.pop_front());
      end
      if (v && exp_rdy) begin
         m_sum += dd;
         m_cnt++;
         if (m_cnt == 64 || l) begin
            exp_q.push_back(frame_result(m_sum, m_cnt));
            m_sum = 0;
            m_cnt = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      m_sum = 0;
      m_cnt = 0;
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_data", bus.out_data, 16'd0);
      chk("rst_out_sat", bus.out_sat, 1'b0);
      chk("rst_out_short", bus.out_short, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int frames;
      int cycles;

      @(negedge clk);
      do_reset();

      // Full frame of 100s: 6432 >> 6 = 100.
      for (int i = 0; i < 64; i++) step(1'b1, 100, 1'b0, 1'b1);
      #1;
      chk("full_valid", bus.out_valid, 1'b1);
      chk("full_data", bus.out_data, 16'd100);
      chk("full_sat", bus.out_sat, 1'b0);
      chk("full_short", bus.out_short, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);

      // Saturating frame.
      for (int i = 0; i < 64; i++) step(1'b1, 2097151, 1'b0, 1'b1);
      #1;
      chk("sat_data", bus.out_data, 16'd65535);
      chk("sat_flag", bus.out_sat, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Rounding boundary on single-sample short frames.
      step(1'b1, 32, 1'b1, 1'b1);
      #1;
      chk("round32_data", bus.out_data, 16'd1);
      chk("round32_short", bus.out_short, 1'b1);
      step(1'b1, 31, 1'b1, 1'b1);
      #1;
      chk("round31_data", bus.out_data, 16'd0);
      chk("round31_valid", bus.out_valid, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);

      // Backpressure across two frames of 64s.
      for (int i = 0; i < 64; i++) step(1'b1, 64, 1'b0, 1'b0);
      for (int i = 0; i < 63; i++) step(1'b1, 64, 1'b0, 1'b0);
      repeat (3) step(1'b1, 64, 1'b0, 1'b0);
      #1;
      chk("bp_stall_ready", bus.in_ready, 1'b0);
      chk("bp_held_data", bus.out_data, 16'd64);
      step(1'b1, 64, 1'b0, 1'b1);
      #1;
      chk("bp_second_valid", bus.out_valid, 1'b1);
      chk("bp_second_data", bus.out_data, 16'd64);
      chk("bp_second_short", bus.out_short, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);

      // Reset in the middle of a frame discards the partial sum.
      for (int i = 0; i < 30; i++) step(1'b1, 5, 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 64; i++) step(1'b1, 1, 1'b0, 1'b1);
      #1;
      chk("postrst_data", bus.out_data, 16'd1);
      chk("postrst_short", bus.out_short, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1);

      // Random gaps, random early close, random downstream stalls.
      frames = 0;
      cycles = 0;
      while (frames < 1000 && cycles < 60000) begin
         int unsigned d;
         int          q_before;
         bit          closes;
         d = ($urandom_range(0, 3) == 0) ? 32'd2097151 - $urandom_range(0, 255)
                                         : $urandom_range(0, 2097151);
         q_before = m_cnt;
         step($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0,
              $urandom_range(0, 2) != 0);
         closes = (m_cnt == 0 && q_before != 0) ||
                  (m_cnt == 0 && q_before == 0 && bus.in_valid && bus.in_last && bus.in_ready);
         if (closes) frames++;
         cycles++;
      end
      chk("rand_frames", frames, 1000);
      repeat (3) step(1'b0, 0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
